// File: rtl/if_id_pkg.sv
// Shared types and defaults for the IF/ID pipeline stage buffer.
package if_id_pkg;

    localparam int          PC_W_DEF   = 32;
    localparam int          INST_W_DEF = 32;
    localparam logic [31:0] NOP_INST   = 32'h0000_0000;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [INST_W_DEF-1:0] inst;
    } if_id_entry_t;

    // A single-entry buffer still needs a one-bit pointer so the port widths stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// Register array backing the IF/ID buffer: one write port, one asynchronous read port.
module pipe_buf_mem #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int AW    = 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Data storage needs no reset: the stage masks the read data whenever it is empty.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/if_id_stage_buf.sv
// IF/ID pipeline stage: DEPTH-entry elastic buffer carrying {PC, instruction} from fetch to decode.
module if_id_stage_buf
    import if_id_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [PC_W-1:0]            pc_i,
    input  logic [INST_W-1:0]          inst_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [PC_W-1:0]            pc_o,
    output logic [INST_W-1:0]          inst_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = PC_W + INST_W;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW-1:0] w_rd_ptr_nxt;
    logic [CW-1:0] w_count_nxt;
    logic          w_full;
    logic          w_valid;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_rd_data;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == AW'(DEPTH - 1)) begin
            return {AW{1'b0}};
        end else begin
            return p + AW'(1);
        end
    endfunction

    assign w_full      = (r_count == CW'(DEPTH));
    assign w_valid     = (r_count != {CW{1'b0}});
    // No pass-through when full: ready depends only on stored occupancy, never on out_ready_i.
    assign in_ready_o  = !w_full && rst_i;
    assign w_push      = in_valid_i && in_ready_o;
    assign w_pop       = w_valid && out_ready_i;

    // Next pointer/count state; flush overrides any push or pop in the same cycle.
    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = r_count;
        if (flush_i) begin
            w_wr_ptr_nxt = {AW{1'b0}};
            w_rd_ptr_nxt = {AW{1'b0}};
            w_count_nxt  = {CW{1'b0}};
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = ptr_inc(r_wr_ptr);
            end else begin
                w_wr_ptr_nxt = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_nxt = ptr_inc(r_rd_ptr);
            end else begin
                w_rd_ptr_nxt = r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CW'(1);
                2'b01:   w_count_nxt = r_count - CW'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    pipe_buf_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (AW)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (w_push && !flush_i),
        .waddr_i (r_wr_ptr),
        .wdata_i ({pc_i, inst_i}),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_rd_data)
    );

    // An empty stage presents a NOP bubble to decode.
    assign out_valid_o = w_valid;
    assign pc_o        = w_valid ? w_rd_data[EW-1:INST_W] : {PC_W{1'b0}};
    assign inst_o      = w_valid ? w_rd_data[INST_W-1:0]  : INST_W'(NOP_INST);
    assign count_o     = r_count;

endmodule
